// File: rtl/mobilenet_pkg.sv
// Shared types and layer geometry for the weight/bias address streamer.
// Segment boundaries are derived from the per-part channel tables below.
package mobilenet_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        WEIGHTS = 2'd1,
        BIAS    = 2'd2
    } seg_kind_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [1:0] LT_CONV     = 2'd0;
    localparam logic [1:0] LT_DW       = 2'd1;
    localparam logic [1:0] LT_PW       = 2'd2;
    localparam logic [1:0] LT_PW_SPLIT = 2'd3;

    // A "part" is one weight segment plus its bias segment; the split
    // pointwise layer occupies two parts, each covering half the outputs.
    localparam int NUM_PARTS = 28;

    localparam logic [1:0] PART_TYPE [NUM_PARTS] = '{
        LT_CONV,
        LT_DW, LT_PW, LT_DW, LT_PW, LT_DW, LT_PW, LT_DW, LT_PW,
        LT_DW, LT_PW, LT_DW, LT_PW,
        LT_DW, LT_PW, LT_DW, LT_PW, LT_DW, LT_PW, LT_DW, LT_PW, LT_DW, LT_PW,
        LT_DW, LT_PW, LT_DW, LT_PW_SPLIT, LT_PW_SPLIT
    };

    localparam int PART_CIN [NUM_PARTS] = '{
        3,
        8, 8, 16, 16, 32, 32, 32, 32,
        64, 64, 64, 64,
        128, 128, 128, 128, 128, 128, 128, 128, 128, 128,
        128, 128, 256, 256, 256
    };

    localparam int PART_COUT [NUM_PARTS] = '{
        8,
        8, 16, 16, 32, 32, 32, 32, 64,
        64, 64, 64, 128,
        128, 128, 128, 128, 128, 128, 128, 128, 128, 128,
        128, 256, 256, 256, 256
    };

    function automatic int weight_size(input int p, input int conv_size);
        int n;
        case (PART_TYPE[p])
            LT_CONV: n = PART_CIN[p] * PART_COUT[p] * conv_size;
            LT_DW:   n = PART_COUT[p] * conv_size;
            LT_PW:   n = PART_CIN[p] * PART_COUT[p];
            default: n = (PART_CIN[p] * PART_COUT[p]) >> 1;
        endcase
        return n;
    endfunction

    function automatic int bias_size(input int p);
        return (PART_TYPE[p] == LT_PW_SPLIT) ? (PART_COUT[p] >> 1) : PART_COUT[p];
    endfunction

    function automatic int weight_end(input int p, input int conv_size);
        int acc;
        acc = 0;
        for (int i = 0; i <= p; i++) acc = acc + weight_size(i, conv_size);
        return acc;
    endfunction

    function automatic int bias_end(input int p);
        int acc;
        acc = 0;
        for (int i = 0; i <= p; i++) acc = acc + bias_size(i);
        return acc;
    endfunction

endpackage

// File: rtl/seg_table.sv
// Combinational step -> segment lookup. Step 3p+1 is the weight segment of
// part p, step 3p+2 its bias segment; every other step is unmapped.
module seg_table
    import mobilenet_pkg::*;
#(
    parameter int ADDR_W    = 18,
    parameter int STEP_W    = 7,
    parameter int CONV_SIZE = 9,
    parameter int NUM_SEG   = 56
) (
    input  logic [STEP_W-1:0] i_step,
    output logic [ADDR_W-1:0] o_first,
    output logic [ADDR_W-1:0] o_last,
    output seg_kind_t         o_kind
);

    localparam int NUM_ENT = ((NUM_SEG / 2) < NUM_PARTS) ? (NUM_SEG / 2) : NUM_PARTS;

    logic [ADDR_W-1:0] w_wfirst [NUM_ENT];
    logic [ADDR_W-1:0] w_wlast  [NUM_ENT];
    logic [ADDR_W-1:0] w_bfirst [NUM_ENT];
    logic [ADDR_W-1:0] w_blast  [NUM_ENT];

    for (genvar p = 0; p < NUM_ENT; p++) begin : g_part
        assign w_wlast[p]  = ADDR_W'(weight_end(p, CONV_SIZE));
        assign w_wfirst[p] = ADDR_W'(weight_end(p, CONV_SIZE) - weight_size(p, CONV_SIZE));
        assign w_blast[p]  = ADDR_W'(bias_end(p));
        assign w_bfirst[p] = ADDR_W'(bias_end(p) - bias_size(p));
    end

    always_comb begin
        o_first = '0;
        o_last  = '0;
        o_kind  = NONE;
        for (int p = 0; p < NUM_ENT; p++) begin
            if (i_step == STEP_W'(3 * p + 1)) begin
                o_first = w_wfirst[p];
                o_last  = w_wlast[p];
                o_kind  = WEIGHTS;
            end else if (i_step == STEP_W'(3 * p + 2)) begin
                o_first = w_bfirst[p];
                o_last  = w_blast[p];
                o_kind  = BIAS;
            end
        end
    end

endmodule

// File: rtl/weight_addr_streamer.sv
// Streams the address range [first, last) of one weight or bias segment
// over a valid/ready port, selected by a network step index.
module weight_addr_streamer
    import mobilenet_pkg::*;
#(
    parameter int ADDR_W    = 18,
    parameter int STEP_W    = 7,
    parameter int CONV_SIZE = 9,
    parameter int NUM_SEG   = 56
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [STEP_W-1:0] step,
    input  logic              abort,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              addr_last,
    output logic              re_weights,
    output logic              re_bias,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            r_state;
    state_t            w_next_state;
    logic [STEP_W-1:0] r_step;
    logic [ADDR_W-1:0] r_last;
    logic [ADDR_W-1:0] r_cur;
    seg_kind_t         r_kind;
    logic              r_err;
    logic              w_err_next;
    logic [ADDR_W-1:0] w_first;
    logic [ADDR_W-1:0] w_last;
    seg_kind_t         w_kind;
    logic              w_is_last;
    logic              w_active;

    seg_table #(
        .ADDR_W    (ADDR_W),
        .STEP_W    (STEP_W),
        .CONV_SIZE (CONV_SIZE),
        .NUM_SEG   (NUM_SEG)
    ) u_seg_table (
        .i_step  (r_step),
        .o_first (w_first),
        .o_last  (w_last),
        .o_kind  (w_kind)
    );

    assign w_is_last = (r_cur == (r_last - ADDR_W'(1)));

    always_comb begin
        w_next_state = r_state;
        w_err_next   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next_state = LOOKUP;
            end
            LOOKUP: begin
                if (abort) begin
                    w_next_state = IDLE;
                end else if (w_kind == NONE) begin
                    w_next_state = IDLE;
                    w_err_next   = 1'b1;
                end else if (w_first == w_last) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = STREAM;
                end
            end
            STREAM: begin
                // abort wins over a same-cycle handshake
                if (abort) w_next_state = IDLE;
                else if (addr_ready && w_is_last) w_next_state = DONE;
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_last  <= '0;
            r_cur   <= '0;
            r_kind  <= NONE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_err   <= w_err_next;
            if (r_state == IDLE && start) r_step <= step;
            if (r_state == LOOKUP) begin
                r_last <= w_last;
                r_kind <= w_kind;
                r_cur  <= w_first;
            end else if (r_state == STREAM && addr_ready && !abort) begin
                r_cur <= r_cur + ADDR_W'(1);
            end
        end
    end

    assign w_active   = (r_state == STREAM) || (r_state == DONE);
    assign addr       = r_cur;
    assign addr_valid = (r_state == STREAM);
    assign addr_last  = addr_valid && w_is_last;
    assign re_weights = w_active && (r_kind == WEIGHTS);
    assign re_bias    = w_active && (r_kind == BIAS);
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign err        = r_err;

endmodule
